alu_split: RTL and testbench

ALU_SPLIT -- requirements
Module: alu_split

---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_split_if.sv | 35 +++
 rtl/alu_split.sv | 73 +++++++
 tb/tb_alu_split.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths and FSM state encoding for the word-to-nibble splitter.
package alu_pkg;

  localparam int NIB_W  = 4;
  localparam int WORD_W = 2 * NIB_W;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HI    = 2'd1;
  localparam logic [1:0] ST_LO    = 2'd2;

endpackage

// File: rtl/alu_split_if.sv
// Handshake bundle between a word producer, the splitter and a nibble consumer.
interface alu_split_if;

  logic                        in_valid;
  logic                        in_ready;
  logic [alu_pkg::WORD_W-1:0]  in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [alu_pkg::NIB_W-1:0]   out_nib;
  logic                        out_hi;
  logic [7:0]                  pair_cnt;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_nib,
    output out_hi,
    output pair_cnt
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_nib,
    input  out_hi,
    input  pair_cnt
  );

endinterface

// File: rtl/alu_split.sv
// Splits each accepted {A,B} word into A then B nibbles; A appears the cycle after capture.
// Backpressure: out_ready stalls the held word; a new word is accepted only while B leaves.
module alu_split
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  alu_split_if.slave  bus
);

  logic [1:0]        state;
  logic [WORD_W-1:0] hold;
  logic [7:0]        cnt;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = bus.in_valid  & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  // Handshake outputs depend only on state and out_ready, never on in_valid.
  always_comb begin
    bus.in_ready  = 1'b1;
    bus.out_valid = 1'b0;
    bus.out_hi    = 1'b0;
    bus.out_nib   = '0;
    case (state)
      ST_HI: begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b1;
        bus.out_hi    = 1'b1;
        bus.out_nib   = hold[WORD_W-1:NIB_W];
      end
      ST_LO: begin
        bus.in_ready  = bus.out_ready;
        bus.out_valid = 1'b1;
        bus.out_nib   = hold[NIB_W-1:0];
      end
      default: begin
        bus.in_ready  = 1'b1;
      end
    endcase
  end

  assign bus.pair_cnt = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      hold  <= '0;
      cnt   <= 8'd0;
    end else begin
      if (in_xfer) begin
        hold <= bus.in_data;
      end
      case (state)
        ST_EMPTY: begin
          if (in_xfer) state <= ST_HI;
        end
        ST_HI: begin
          if (out_xfer) state <= ST_LO;
        end
        ST_LO: begin
          if (out_xfer) begin
            cnt   <= cnt + 8'd1;
            state <= in_xfer ? ST_HI : ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_split.sv
// Directed bench for alu_split with a nibble scoreboard fed on every accepted word.
module tb_alu_split;

  typedef struct packed {
    logic       hi;
    logic [3:0] nib;
  } exp_t;

  logic clk;
  logic rst_n;
  alu_split_if bus ();

  alu_split dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_cmp;
  int   n_bad;
  exp_t sb[$];
  logic [7:0] exp_pairs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on output transfer, push on input transfer, both sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL sb_extra observed=%0h expected=none", {bus.out_hi, bus.out_nib});
      end else begin
        e = sb.pop_front();
        chk("sb_nibble", {27'd0, bus.out_hi, bus.out_nib}, {27'd0, e.hi, e.nib});
        if (!e.hi) exp_pairs = exp_pairs + 8'd1;
      end
    end
    if (rst_n === 1'b1 && bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
      sb.push_back('{hi: 1'b1, nib: bus.in_data[7:4]});
      sb.push_back('{hi: 1'b0, nib: bus.in_data[3:0]});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] words [3];
    logic       pat   [5];
    logic [7:0] cur;
    logic       took;
    int         k;
    int         sent;

    n_cmp = 0;
    n_bad = 0;
    exp_pairs = 8'd0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state, during and after reset
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_nib",   {28'd0, bus.out_nib},   32'd0);
    chk("rst_out_hi",    {31'd0, bus.out_hi},    32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_pair_cnt",  {24'd0, bus.pair_cnt},  32'd0);
    #22;
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_rst_ready", {31'd0, bus.in_ready},  32'd1);

    // Single word A5
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    chk("a5_hi_nib",   {28'd0, bus.out_nib},   32'hA);
    chk("a5_hi_flag",  {31'd0, bus.out_hi},    32'd1);
    chk("a5_hi_ready", {31'd0, bus.in_ready},  32'd0);
    tick();
    chk("a5_lo_nib",   {28'd0, bus.out_nib},   32'h5);
    chk("a5_lo_flag",  {31'd0, bus.out_hi},    32'd0);
    tick();
    chk("a5_pairs",    {24'd0, bus.pair_cnt},  32'd1);
    chk("a5_idle",     {31'd0, bus.out_valid}, 32'd0);

    // Back-to-back stream 12,34,56
    words = '{8'h12, 8'h34, 8'h56};
    pat   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (c < 5) chk("stream_in_ready", {31'd0, bus.in_ready}, {31'd0, pat[c]});
      bus.in_valid = (k < 3);
      bus.in_data  = (k < 3) ? words[k] : 8'h00;
      took = bus.in_valid & bus.in_ready;
      tick();
      if (took) k++;
      chk("stream_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_idle",  {31'd0, bus.out_valid}, 32'd0);
    chk("stream_pairs", {24'd0, bus.pair_cnt},  {24'd0, exp_pairs});
    chk("stream_pairs4",{24'd0, bus.pair_cnt},  32'd4);

    // Stall with C3 held in HI
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hC3;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("stall_nib",   {28'd0, bus.out_nib},  32'hC);
      chk("stall_hi",    {31'd0, bus.out_hi},   32'd1);
      chk("stall_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("stall_lo_nib", {28'd0, bus.out_nib}, 32'h3);
    tick();

    // LO stalled with 9E offered, then B and capture on the same edge
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h7B;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("lo_reach_nib", {28'd0, bus.out_nib}, 32'hB);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h9E;
    #1;
    chk("lo_stall_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk("lo_stall_nib",  {28'd0, bus.out_nib}, 32'hB);
    chk("lo_stall_hi",   {31'd0, bus.out_hi},  32'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("lo_go_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("lo_next_nib", {28'd0, bus.out_nib}, 32'h9);
    chk("lo_next_hi",  {31'd0, bus.out_hi},  32'd1);
    tick();
    chk("lo_next_b",   {28'd0, bus.out_nib}, 32'hE);
    tick();

    // Reset while F0 sits in HI
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hF0;
    tick();
    bus.in_valid = 1'b0;
    chk("f0_held", {28'd0, bus.out_nib}, 32'hF);
    #2;
    rst_n = 1'b0;
    sb.delete();
    exp_pairs = 8'd0;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_nib",   {28'd0, bus.out_nib},   32'd0);
    chk("arst_ready", {31'd0, bus.in_ready},  32'd1);
    chk("arst_pairs", {24'd0, bus.pair_cnt},  32'd0);
    #3;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("arst_after_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("arst_after_pairs", {24'd0, bus.pair_cnt},  32'd0);

    // 256 words wrap the pair counter, 257th brings it to 1
    sent = 0;
    cur = 8'($urandom_range(0, 255));
    bus.in_valid = 1'b1;
    for (int c = 0; c < 2000 && sent < 256; c++) begin
      bus.in_data = cur;
      took = bus.in_ready;
      tick();
      if (took) begin
        sent++;
        cur = 8'($urandom_range(0, 255));
      end
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4 && bus.out_valid === 1'b1; i++) tick();
    chk("wrap_sent",   sent, 256);
    chk("wrap_drain",  {31'd0, bus.out_valid}, 32'd0);
    chk("wrap_pairs0", {24'd0, bus.pair_cnt},  32'd0);
    chk("wrap_model",  {24'd0, bus.pair_cnt},  {24'd0, exp_pairs});
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("wrap_pairs1", {24'd0, bus.pair_cnt}, 32'd1);
    chk("sb_drained",  sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
